// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - shared operand-select encodings and load-wait FSM states
package fwd_pkg;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } fsm_state_t;

    // Width of the load-latency down-counter: ceil(log2(mem_lat)), never below 1 bit.
    function automatic int lat_width(input int mem_lat);
        return (mem_lat > 1) ? $clog2(mem_lat) : 1;
    endfunction

endpackage

// File: rtl/fwd_src_sel.sv
// rtl/fwd_src_sel.sv - per-operand forwarding select and hazard detection
module fwd_src_sel
    import fwd_pkg::*;
#(
    parameter int REG_W = 4
) (
    input  logic             fwd_en,
    input  logic [REG_W-1:0] src,
    input  logic             src_valid,
    input  logic             exe_wb,
    input  logic             exe_is_load,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             mem_wb,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             wb_wb,
    input  logic [REG_W-1:0] wb_dest,
    output logic [1:0]       sel,
    output logic             hazard
);

    logic exe_hit;
    logic mem_hit;
    logic wb_hit;

    assign exe_hit = exe_wb && (src == exe_dest);
    assign mem_hit = mem_wb && (src == mem_dest);
    assign wb_hit  = wb_wb  && (src == wb_dest);

    // Pick the youngest producer (MEM over WB); a load still in EXE cannot forward yet.
    always_comb begin
        sel    = SEL_RF;
        hazard = 1'b0;
        if (src_valid) begin
            if (fwd_en) begin
                if (exe_hit && exe_is_load) begin
                    hazard = 1'b1;
                end else if (mem_hit) begin
                    sel = SEL_MEM;
                end else if (wb_hit) begin
                    sel = SEL_WB;
                end
            end else begin
                hazard = exe_hit || mem_hit;
            end
        end
    end

endmodule

// File: rtl/forward_hazard_unit.sv
// rtl/forward_hazard_unit.sv - operand forwarding, load-use hazard and multi-cycle load freeze
module forward_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_W   = 4,
    parameter int NUM_SRC = 3,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fwd_en,
    input  logic [NUM_SRC*REG_W-1:0] src,
    input  logic [NUM_SRC-1:0]       src_valid,
    input  logic                     exe_wb,
    input  logic                     exe_is_load,
    input  logic [REG_W-1:0]         exe_dest,
    input  logic                     mem_wb,
    input  logic                     mem_is_load,
    input  logic [REG_W-1:0]         mem_dest,
    input  logic                     wb_wb,
    input  logic [REG_W-1:0]         wb_dest,
    input  logic                     cnt_clr,
    output logic [NUM_SRC*2-1:0]     sel,
    output logic                     hazard,
    output logic                     freeze,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam int              LAT_W     = lat_width(MEM_LAT);
    localparam bit              LOAD_ARMS = (MEM_LAT > 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);

    logic [NUM_SRC-1:0] src_hazard;
    fsm_state_t         state;
    fsm_state_t         state_nxt;
    logic [LAT_W-1:0]   lat_cnt;
    logic [LAT_W-1:0]   lat_cnt_nxt;
    logic               freeze_nxt;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        fwd_src_sel #(
            .REG_W(REG_W)
        ) u_src_sel (
            .fwd_en     (fwd_en),
            .src        (src[g*REG_W +: REG_W]),
            .src_valid  (src_valid[g]),
            .exe_wb     (exe_wb),
            .exe_is_load(exe_is_load),
            .exe_dest   (exe_dest),
            .mem_wb     (mem_wb),
            .mem_dest   (mem_dest),
            .wb_wb      (wb_wb),
            .wb_dest    (wb_dest),
            .sel        (sel[g*2 +: 2]),
            .hazard     (src_hazard[g])
        );
    end

    // A frozen pipeline never needs a bubble on top of the freeze.
    assign hazard = (|src_hazard) && !freeze;

    // Next-state logic: a load in MEM arms the wait, lat_cnt counts the remaining extra cycles.
    always_comb begin
        state_nxt   = state;
        lat_cnt_nxt = lat_cnt;
        freeze_nxt  = freeze;
        case (state)
            ST_IDLE: begin
                if (LOAD_ARMS && mem_wb && mem_is_load) begin
                    state_nxt   = ST_WAIT;
                    lat_cnt_nxt = LAT_LOAD;
                    freeze_nxt  = 1'b1;
                end
            end
            ST_WAIT: begin
                if (lat_cnt == '0) begin
                    state_nxt  = ST_IDLE;
                    freeze_nxt = 1'b0;
                end else begin
                    lat_cnt_nxt = lat_cnt - 1'b1;
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                lat_cnt_nxt = '0;
                freeze_nxt  = 1'b0;
            end
        endcase
    end

    // FSM state register; reset aborts any wait immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            lat_cnt <= '0;
            freeze  <= 1'b0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_cnt_nxt;
            freeze  <= freeze_nxt;
        end
    end

    // Saturating count of lost cycles; clear takes precedence over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if ((hazard || freeze) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: doc/forward_hazard_unit.md
FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 Parameter REG_W, default 4: register-index width.
REQ-002 Parameter NUM_SRC, default 3: number of source operands checked per cycle.
REQ-003 Parameter MEM_LAT, default 1, legal 1..8: data-memory latency in cycles.
REQ-004 Parameter CNT_W, default 16: stall-counter width.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 fwd_en  in  1  1 = forwarding mode; 0 = stall-only mode.
REQ-008 src  in  NUM_SRC*REG_W  ID-stage source indices; operand i is slice i.
REQ-009 src_valid  in  NUM_SRC  per-operand "operand is read" flag.
REQ-010 exe_wb, exe_is_load  in  1 each  EXE-stage writeback enable and load flag.
REQ-011 exe_dest  in  REG_W  EXE-stage destination.
REQ-012 mem_wb, mem_is_load  in  1 each  MEM-stage writeback enable and load flag.
REQ-013 mem_dest  in  REG_W  MEM-stage destination.
REQ-014 wb_wb  in  1;  wb_dest  in  REG_W  WB-stage writeback enable and destination.
REQ-015 cnt_clr  in  1  synchronous clear of stall_cnt.
REQ-016 sel  out  NUM_SRC*2  per-operand mux select: 00 regfile, 01 MEM result, 10 WB result.
REQ-017 hazard  out  1  insert one bubble: hold IF/ID, flush ID/EXE.
REQ-018 freeze  out  1  hold the entire pipeline while a load is in flight.
REQ-019 stall_cnt  out  CNT_W  saturating count of hazard-or-freeze cycles.

Function
REQ-020 sel and hazard SHALL be combinational from the current inputs and state (zero latency); freeze and stall_cnt SHALL be registered.
REQ-021 An operand with src_valid[i]=0 SHALL produce sel=00 and SHALL NOT contribute to hazard.
REQ-022 fwd_en=1, operand i: if exe_wb & exe_is_load & src_i==exe_dest, raise hazard (load-use) and set sel_i=00.
REQ-023 Otherwise, if mem_wb & src_i==mem_dest, set sel_i=01; otherwise, if wb_wb & src_i==wb_dest, set sel_i=10; otherwise set sel_i=00. A MEM match SHALL take priority over a WB match.
REQ-024 fwd_en=0: set every sel=00; raise hazard if any valid src_i equals exe_dest with exe_wb=1, or equals mem_dest with mem_wb=1.
REQ-025 hazard SHALL be the OR over all operands; several operands matching in the same cycle SHALL raise a single hazard.
REQ-026 FSM states: IDLE and WAIT; lat_cnt is a ceil(log2(MEM_LAT))-bit down-counter, minimum 1 bit.
REQ-027 IDLE to WAIT when MEM_LAT>1 and mem_wb & mem_is_load; on that transition load lat_cnt with MEM_LAT-2 and set freeze=1 from the next cycle.
REQ-028 WAIT: decrement lat_cnt each cycle; when lat_cnt==0, return to IDLE and clear freeze on the same edge.
REQ-029 With MEM_LAT=1 the FSM SHALL remain in IDLE and freeze SHALL stay 0.
REQ-030 While freeze=1, hazard SHALL be forced to 0; sel SHALL still be computed from the held inputs.
REQ-031 In WAIT, a new load is ignored; a load is not re-armed until the cycle after the return to IDLE.
REQ-032 stall_cnt SHALL increment by 1 in any cycle where hazard|freeze, and SHALL saturate at all-ones without wrapping.
REQ-033 cnt_clr SHALL win over an increment in the same cycle, giving 0.

Reset
REQ-034 While rst_n=0: state=IDLE, lat_cnt=0, freeze=0, stall_cnt=0, independent of clk.
REQ-035 Reset assertion mid-WAIT SHALL abort the wait immediately; the combinational outputs then follow the inputs with state IDLE.

Structure
REQ-036 Shared package fwd_pkg SHALL hold the sel encodings (SEL_RF, SEL_MEM, SEL_WB) and the FSM state enum.
REQ-037 One sub-module, fwd_src_sel, SHALL hold the per-operand match/priority logic and be instantiated NUM_SRC times by a generate loop.

Verification
REQ-038 fwd_en=1; src0=3 valid; mem_wb=1, mem_dest=3; wb_wb=1, wb_dest=3 -> sel0=01, hazard=0.
REQ-039 fwd_en=1; src1=5; exe_wb=1, exe_is_load=1, exe_dest=5 -> hazard=1, sel1=00, stall_cnt +1 after the clock edge.
REQ-040 fwd_en=0; src0=2; wb_wb=1, wb_dest=2; no EXE/MEM match -> hazard=0, sel0=00.
REQ-041 MEM_LAT=3; one-cycle mem_wb=1, mem_is_load=1 -> freeze=1 for exactly 2 cycles, then 0; a second load pulse during WAIT is ignored.
REQ-042 Preload stall_cnt to all-ones via CNT_W=4 and 16 hazard cycles; one further hazard -> stays 15; cnt_clr together with hazard -> 0.
REQ-043 rst_n driven low asynchronously mid-WAIT -> freeze=0 and stall_cnt=0 before the next clk edge.
